hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

Parametrised hazard and forwarding controller for the five-stage RISC-V pipeline (F/D/E/M/W). It supersedes the single-cycle hazard unit and adds a multi-cycle execute (MDU) stall sequencer with an M-stage bubble. It also adds a compile-time forwarding-disable mode and a saturating stall-cycle performance counter. It sits beside the datapath and drives every stage's stall, flush and forward-select control.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; x0 is address 0.
- MDU_LATENCY, 4, total cycles a long-latency op occupies E (≥1).
- FWD_EN, 1, 1 = M/W→E forwarding enabled; 0 = no forwarding, resolve all RAW by stalling.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_W  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  sources and destination of the instruction in E.
- RdM, RdW  in  REG_ADDR_W  destinations in M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable of the instruction in E/M/W.
- ResultSrcE0  in  1  the instruction in E is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MulStartE  in  1  the instruction in E is an MDU op.
- StallF, StallD, StallE  out  1  hold the PC, the D register and the E register.
- FlushD, FlushE, FlushM  out  1  insert a bubble into D, E or M on the next edge.
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALU result from M, 01 = result from W.
- MduBusy  out  1  MDU op in E still iterating.
- StallCycles  out  CNT_W  saturating count of cycles with StallF=1.

## Operation
- Hazard test: a register is hazardous only if it is nonzero and matches the destination of a stage whose RegWrite is set. x0 never stalls and never forwards.
- Forwarding (FWD_EN=1), ForwardAE:
  - 10 if RegWriteM, RdM≠0 and RdM==Rs1E.
  - else 01 if RegWriteW, RdW≠0 and RdW==Rs1E.
  - else 00.
  - M has priority over W. ForwardBE uses the same rules with Rs2E.
- FWD_EN=0: ForwardAE and ForwardBE are tied to 00. D stalls (StallF, StallD, FlushE) while Rs1D or Rs2D is hazardous against E or M. W is excluded because the register file is write-first.
- Load-use (FWD_EN=1): ResultSrcE0, RdE≠0 and RdE equals Rs1D or Rs2D → StallF=StallD=FlushE=1 for one cycle.
- Control hazard: PCSrcE → FlushD=FlushE=1. The flush overrides a simultaneous load-use or no-forward stall: StallF and StallD are 0 that cycle.
- MDU sequencer:
  - Register cnt, ceil(log2(MDU_LATENCY)) bits wide, at least 1 bit.
  - MduBusy = MulStartE and (cnt < MDU_LATENCY−1).
  - While MduBusy: StallF=StallD=StallE=1, FlushM=1, FlushE=0, FlushD=0, and cnt increments.
  - On the cycle where MulStartE and cnt==MDU_LATENCY−1: MduBusy=0, the op advances, and cnt clears to 0.
  - MDU_LATENCY=1 never asserts MduBusy.
  - The datapath latches MDU operands when cnt==0, using that cycle's forward selects.
- Priority, highest first:
  1. Reset.
  2. MduBusy.
  3. PCSrcE.
  4. Load-use or no-forward stall.
- MulStartE dropping while cnt≠0 (only possible through a flush) clears cnt on the next edge.
- StallCycles increments on each edge where StallF=1. It holds at all-ones and does not wrap.

## Timing
- Every output except StallCycles is combinational from the inputs and cnt. There is zero-cycle latency to the pipeline registers.
- cnt and StallCycles update on the rising edge of clk.
- While rst=0: cnt=0, StallCycles=0, and all stall, flush, forward and MduBusy outputs are forced to 0. This holds asynchronously, including mid-MDU-op.
- After rst rises, an MDU op already in E restarts at cnt=0.
- An MDU op costs exactly MDU_LATENCY−1 stall cycles and MDU_LATENCY−1 M bubbles.

## Test plan
- Forward priority: RdM=RdW=Rs1E=5 with RegWriteM and RegWriteW set → ForwardAE=10. Clear RegWriteM → 01. Rs1E=0 with RdM=0 → 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → one cycle of StallF=StallD=FlushE=1, and StallCycles increments by 1. With RdE=0 → no stall.
- Flush over stall: load-use condition plus PCSrcE=1 in the same cycle → FlushD=FlushE=1, StallF=StallD=0.
- MDU, MDU_LATENCY=4: MulStartE held high → MduBusy with StallF/D/E and FlushM high for 3 cycles, low on the 4th, and cnt sequence 0,1,2,3,0. With MDU_LATENCY=1 → never busy.
- FWD_EN=0: RegWriteM=1, RdM=3, Rs1D=3 → stall until the producer reaches W; ForwardAE/BE stay 00.
- Reset mid-op: pull rst low when cnt=2 → outputs go to 0 immediately; after release cnt=0. Force StallF high for 2^CNT_W+2 cycles with CNT_W=4 → StallCycles saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline stall/flush/forward control with a multi-cycle MDU sequencer and a stall-cycle counter
module hazard_ctrl_mc #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4,
  parameter bit FWD_EN      = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  MulStartE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MduBusy,
  output logic [CNT_W-1:0]      StallCycles
);
  localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MDU_LATENCY - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic busy, lu_stall, nf_stall, stall;
  function automatic logic hit(input logic [REG_ADDR_W-1:0] rs, rd, input logic we);
    return we && (rd != '0) && (rd == rs);
  endfunction
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs, rdm, rdw, input logic wm, ww);
    return hit(rs, rdm, wm) ? 2'b10 : hit(rs, rdw, ww) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    busy = MulStartE && (cnt_q < CNT_LAST);
    lu_stall = FWD_EN && ResultSrcE0 && (hit(Rs1D, RdE, 1'b1) || hit(Rs2D, RdE, 1'b1));
    // register file is write-first, so only E and M producers block D without forwarding
    nf_stall = !FWD_EN && (hit(Rs1D, RdE, RegWriteE) || hit(Rs2D, RdE, RegWriteE) ||
                           hit(Rs1D, RdM, RegWriteM) || hit(Rs2D, RdM, RegWriteM));
    stall = !busy && !PCSrcE && (lu_stall || nf_stall);
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    StallF = rst && (busy || stall);
    StallD = StallF;
    StallE = rst && busy;
    FlushM = StallE;
    MduBusy = StallE;
    FlushD = rst && !busy && PCSrcE;
    FlushE = rst && !busy && (PCSrcE || stall);
    ForwardAE = (rst && FWD_EN) ? fwd(Rs1E, RdM, RdW, RegWriteM, RegWriteW) : 2'b00;
    ForwardBE = (rst && FWD_EN) ? fwd(Rs2E, RdM, RdW, RegWriteM, RegWriteW) : 2'b00;
    sc_d = (StallF && !(&sc_q)) ? sc_q + 1'b1 : sc_q;
    StallCycles = sc_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sc_q <= sc_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: scoreboard bench for hazard_ctrl_mc (forwarding, latency-4 MDU, no-forward and latency-1 variants)
module tb_hazard_ctrl_mc;
  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [5:0] fl;
  } stim_t;
  typedef struct {
    logic [10:0] c;
    logic [3:0]  sc;
    logic [1:0]  cnt;
  } exp_t;
  localparam logic [10:0] IDLE = 11'b00000000000;
  localparam logic [10:0] LU   = 11'b11001000000;
  localparam logic [10:0] FL   = 11'b00011000000;
  localparam logic [10:0] BUSY = 11'b11100100001;
  localparam logic [10:0] AE10 = 11'b00000010000;
  localparam logic [10:0] AE01 = 11'b00000001000;
  localparam logic [10:0] BE10 = 11'b00000000100;
  localparam logic [10:0] BE01 = 11'b00000000010;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE;
  logic m_sf, m_sd, m_se, m_fd, m_fe, m_fm, m_busy;
  logic [1:0] m_fa, m_fb;
  logic [3:0] m_sc;
  logic n_sf, n_sd, n_se, n_fd, n_fe, n_fm, n_busy;
  logic [1:0] n_fa, n_fb;
  logic [31:0] n_sc;
  logic l_sf, l_sd, l_se, l_fd, l_fe, l_fm, l_busy;
  logic [1:0] l_fa, l_fb;
  logic [31:0] l_sc;
  exp_t exp_q[$];
  logic [3:0] sc_m;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hazard_ctrl_mc #(.REG_ADDR_W(5), .MDU_LATENCY(4), .FWD_EN(1'b1), .CNT_W(4)) u_main (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MulStartE(MulStartE), .StallF(m_sf), .StallD(m_sd), .StallE(m_se), .FlushD(m_fd),
    .FlushE(m_fe), .FlushM(m_fm), .ForwardAE(m_fa), .ForwardBE(m_fb), .MduBusy(m_busy), .StallCycles(m_sc));
  hazard_ctrl_mc #(.REG_ADDR_W(5), .MDU_LATENCY(4), .FWD_EN(1'b0), .CNT_W(32)) u_nf (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MulStartE(MulStartE), .StallF(n_sf), .StallD(n_sd), .StallE(n_se), .FlushD(n_fd),
    .FlushE(n_fe), .FlushM(n_fm), .ForwardAE(n_fa), .ForwardBE(n_fb), .MduBusy(n_busy), .StallCycles(n_sc));
  hazard_ctrl_mc #(.REG_ADDR_W(5), .MDU_LATENCY(1), .FWD_EN(1'b1), .CNT_W(32)) u_l1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .MulStartE(MulStartE), .StallF(l_sf), .StallD(l_sd), .StallE(l_se), .FlushD(l_fd),
    .FlushE(l_fe), .FlushM(l_fm), .ForwardAE(l_fa), .ForwardBE(l_fb), .MduBusy(l_busy), .StallCycles(l_sc));
  function automatic stim_t st(int a, int b, int c, int d, int e, int f, int g, logic [5:0] fl);
    return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f), 5'(g), fl};
  endfunction
  function automatic logic [16:0] obs_m();
    return {m_sf, m_sd, m_se, m_fd, m_fe, m_fm, m_fa, m_fb, m_busy, m_sc, u_main.cnt_q};
  endfunction
  function automatic logic [44:0] obs_n();
    return {n_sf, n_sd, n_se, n_fd, n_fe, n_fm, n_fa, n_fb, n_busy, n_sc, u_nf.cnt_q};
  endfunction
  task automatic drive(input stim_t s);
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = {s.rs1d, s.rs2d, s.rs1e, s.rs2e, s.rde, s.rdm, s.rdw};
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE} = s.fl;
  endtask
  task automatic push(input logic [10:0] c, input logic [1:0] cn);
    exp_q.push_back('{c: c, sc: sc_m, cnt: cn});
    if (c[10] && sc_m != 4'hF) sc_m++;
  endtask
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive('0);
    @(posedge clk); #1;
    rst = 1'b1;
    sc_m = '0;
    exp_q.delete();
  endtask
  task automatic test_reset();
    exp_t e;
    logic [16:0] got;
    rst = 1'b0;
    sc_m = '0;
    drive(st(7, 7, 5, 5, 7, 5, 5, 6'b111111));
    for (int i = 0; i < 2; i++) begin
      push(IDLE, 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL reset_hold[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
      checks++;
      if (obs_n() !== 45'd0) begin failures++; $display("FAIL reset_hold_nf[%0d] got=%h want=0", i, obs_n()); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive('0);
    push(IDLE, 2'd0);
    @(negedge clk);
    e = exp_q.pop_front(); got = obs_m(); checks++;
    if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL reset_release got=%h want=%h", got, {e.c, e.sc, e.cnt}); end
  endtask
  task automatic test_forward();
    stim_t s[7];
    logic [10:0] c[7];
    exp_t e;
    logic [16:0] got;
    s = '{st(0,0,5,0,0,5,5,6'b011000), st(0,0,5,0,0,5,5,6'b001000), st(0,0,0,0,0,0,0,6'b011000),
          st(0,0,9,9,0,9,9,6'b011000), st(0,0,6,4,0,6,4,6'b011000), st(0,0,8,8,0,8,8,6'b000000),
          st(0,0,3,0,0,7,3,6'b011000)};
    c = '{AE10, AE01, IDLE, AE10 | BE10, AE10 | BE01, IDLE, AE01};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL forward[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_load_use();
    stim_t s[6];
    logic [10:0] c[6];
    exp_t e;
    logic [16:0] got;
    apply_reset();
    s = '{st(0,7,0,0,7,0,0,6'b100100), st(0,0,0,0,0,0,0,6'b000000), st(0,0,0,0,0,0,0,6'b100100),
          st(12,0,0,0,12,0,0,6'b100100), st(0,0,0,0,0,0,0,6'b000000), st(5,6,0,0,7,0,0,6'b100100)};
    c = '{LU, IDLE, IDLE, LU, IDLE, IDLE};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL load_use[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_flush();
    stim_t s[3];
    logic [10:0] c[3];
    exp_t e;
    logic [16:0] got;
    s = '{st(0,7,0,0,7,0,0,6'b100110), st(0,0,0,0,0,0,0,6'b000010), st(0,0,0,0,0,0,0,6'b000000)};
    c = '{FL, FL, IDLE};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL flush[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_mdu();
    stim_t s[5];
    logic [10:0] c[5];
    logic [1:0] k[5];
    exp_t e;
    logic [16:0] got;
    apply_reset();
    s = '{st(0,0,5,0,0,5,0,6'b010001), st(0,0,0,0,0,0,0,6'b000011), st(0,7,0,0,7,0,0,6'b100101),
          st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000000)};
    c = '{BUSY | AE10, BUSY, BUSY, IDLE, IDLE};
    k = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], k[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mdu[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
      checks++;
      if ({l_busy, l_se, l_fm} !== 3'b000) begin failures++; $display("FAIL mdu_lat1[%0d] got=%b want=000", i, {l_busy, l_se, l_fm}); end
    end
  endtask
  task automatic test_mdu_abort();
    stim_t s[8];
    logic [10:0] c[8];
    logic [1:0] k[8];
    exp_t e;
    logic [16:0] got;
    apply_reset();
    s = '{st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000010),
          st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000001),
          st(0,0,0,0,0,0,0,6'b000001), st(0,0,0,0,0,0,0,6'b000000)};
    c = '{BUSY, BUSY, FL, BUSY, BUSY, BUSY, IDLE, IDLE};
    k = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], k[i]);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mdu_abort[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_no_forward();
    stim_t s[9];
    logic [10:0] c[9];
    exp_t e;
    logic [44:0] got;
    apply_reset();
    s = '{st(3,0,3,0,0,3,0,6'b010000), st(3,0,3,0,0,0,3,6'b001000), st(0,3,0,3,3,0,0,6'b100000),
          st(0,3,0,3,0,3,0,6'b010000), st(0,3,0,3,0,0,3,6'b001000), st(0,0,0,0,0,0,0,6'b100000),
          st(3,0,0,0,3,0,0,6'b000000), st(3,0,0,0,3,0,0,6'b100010), st(9,0,0,0,9,0,0,6'b100100)};
    c = '{LU, IDLE, LU, LU, IDLE, IDLE, IDLE, FL, LU};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(s[i]); push(c[i], 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_n(); checks++;
      if (got !== {e.c, 28'd0, e.sc, e.cnt}) begin failures++; $display("FAIL no_forward[%0d] got=%h want=%h", i, got, {e.c, 28'd0, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_reset_mid_op();
    exp_t e;
    logic [16:0] got;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(st(0,0,0,0,0,0,0,6'b000001)); push(BUSY, 2'(i));
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mid_op_pre[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
    @(posedge clk); #1;
    push(BUSY, 2'd2);
    #1;
    e = exp_q.pop_front(); got = obs_m(); checks++;
    if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mid_op_cnt2 got=%h want=%h", got, {e.c, e.sc, e.cnt}); end
    #1;
    rst = 1'b0;
    sc_m = '0;
    push(IDLE, 2'd0);
    #1;
    e = exp_q.pop_front(); got = obs_m(); checks++;
    if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mid_op_async got=%h want=%h", got, {e.c, e.sc, e.cnt}); end
    #1;
    rst = 1'b1;
    push(BUSY, 2'd0);
    #1;
    e = exp_q.pop_front(); got = obs_m(); checks++;
    if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mid_op_restart got=%h want=%h", got, {e.c, e.sc, e.cnt}); end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      push((i < 3) ? BUSY : IDLE, 2'(i));
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL mid_op_post[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
    @(posedge clk); #1;
    drive('0);
  endtask
  task automatic test_saturation();
    exp_t e;
    logic [16:0] got;
    apply_reset();
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive((i < 18) ? st(0,7,0,0,7,0,0,6'b100100) : stim_t'('0));
      push((i < 18) ? LU : IDLE, 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL saturate[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  task automatic test_back_to_back();
    exp_t e;
    logic [16:0] got;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive((i < 8) ? st(0,0,0,0,0,0,0,6'b000001) : stim_t'('0));
      push(((i % 4) != 3 && i < 8) ? BUSY : IDLE, (i < 8) ? 2'(i % 4) : 2'd0);
      @(negedge clk);
      e = exp_q.pop_front(); got = obs_m(); checks++;
      if (got !== {e.c, e.sc, e.cnt}) begin failures++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, {e.c, e.sc, e.cnt}); end
    end
  endtask
  initial begin
    drive('0);
    test_reset();
    test_forward();
    test_load_use();
    test_flush();
    test_mdu();
    test_mdu_abort();
    test_no_forward();
    test_reset_mid_op();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
